// File: rtl/message_tx_scheduler.sv
// Purpose : latches per-class send requests and arbitrates them onto CommunicationSender
//           with ack tracking, timeout/retry and an automatic are_you_there heartbeat.
// Latency : a request pulse leads to send_new_message two cycles later when the sender is idle.
// Backpressure: nothing is issued while message_sent is low. Requests are held as pending flags
//           and are never dropped; a repeat request overwrites the latched payload.
//
// Ports:
//   i_clock / i_reset          : clock, synchronous active-high reset
//   i_req_*  + payload inputs  : one-cycle request pulses with the payload to latch
//   i_message_sent             : sender idle/complete level
//   i_message_acked            : ack pulse from the remote receiver
//   o_send_new_message         : one-cycle start pulse to the sender
//   o_*_tx selects / payload   : one-hot message type and payload fields, stable while in flight
//   o_busy                     : scheduler is not IDLE
//   o_link_lost                : one-cycle pulse when retries are exhausted

module message_tx_scheduler #(
    parameter int ACK_TIMEOUT      = 50000,
    parameter int MAX_RETRIES      = 3,
    parameter int HEARTBEAT_CYCLES = 5000000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_req_ball,
    input  logic [8:0] i_ball_y_in,
    input  logic [3:0] i_velocity_x_in,
    input  logic [3:0] i_velocity_y_in,
    input  logic       i_sign_y_in,
    input  logic       i_req_miss,
    input  logic [4:0] i_my_score_in,
    input  logic [4:0] i_your_score_in,
    input  logic       i_you_should_serve_in,
    input  logic       i_req_new_game,
    input  logic       i_you_serve_first_in,
    input  logic       i_req_new_game_ack,
    input  logic       i_message_sent,
    input  logic       i_message_acked,
    output logic       o_send_new_message,
    output logic       o_ball_message_tx,
    output logic       o_miss_message_tx,
    output logic       o_new_game_message_tx,
    output logic       o_new_game_ack_message_tx,
    output logic       o_are_you_there_tx,
    output logic [8:0] o_ball_y_tx,
    output logic [3:0] o_velocity_x_tx,
    output logic [3:0] o_velocity_y_tx,
    output logic       o_sign_y_tx,
    output logic [4:0] o_my_score_tx,
    output logic [4:0] o_your_score_tx,
    output logic       o_you_should_serve_tx,
    output logic       o_you_serve_first_tx,
    output logic       o_busy,
    output logic       o_link_lost
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);
    localparam int IDL_W = $clog2(HEARTBEAT_CYCLES + 1);

    localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRIES);
    localparam logic [IDL_W-1:0] IDLE_LAST = IDL_W'(HEARTBEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_HOLD, S_SENDING, S_WAIT_ACK
    } state_t;

    typedef enum logic [2:0] {
        C_NGA, C_NG, C_MISS, C_BALL, C_AYT
    } cls_t;

    state_t r_state;
    cls_t   r_cls;

    logic r_pend_ball, r_pend_miss, r_pend_ng, r_pend_nga, r_pend_ayt;

    // Latched request payloads; the outputs are reloaded from these on every (re)issue.
    logic [8:0] r_ball_y;
    logic [3:0] r_vel_x;
    logic [3:0] r_vel_y;
    logic       r_sign_y;
    logic [4:0] r_my_score;
    logic [4:0] r_your_score;
    logic       r_you_serve;
    logic       r_serve_first;

    logic [ACK_W-1:0] r_ack_cnt;
    logic [RTY_W-1:0] r_retry_cnt;
    logic [IDL_W-1:0] r_idle_cnt;

    logic w_any_pend;
    cls_t w_win;
    cls_t w_load_cls;
    logic w_start;
    logic w_timeout;
    logic w_retry;
    logic w_load;
    logic w_cls_ack;
    logic w_done;

    always_comb begin
        w_any_pend = r_pend_nga | r_pend_ng | r_pend_miss | r_pend_ball | r_pend_ayt;
        w_win      = C_AYT;
        if (r_pend_nga)       w_win = C_NGA;
        else if (r_pend_ng)   w_win = C_NG;
        else if (r_pend_miss) w_win = C_MISS;
        else if (r_pend_ball) w_win = C_BALL;
    end

    assign w_start   = (r_state == S_IDLE) && w_any_pend && i_message_sent;
    // An ack arriving in the terminal-count cycle wins over the timeout.
    assign w_timeout = (r_state == S_WAIT_ACK) && !i_message_acked && (r_ack_cnt == ACK_LAST);
    assign w_retry   = w_timeout && (r_retry_cnt != RETRY_MAX);
    assign w_load    = w_start || w_retry;
    assign w_cls_ack = (r_cls == C_BALL) || (r_cls == C_MISS) || (r_cls == C_NG);
    assign w_done    = ((r_state == S_SENDING) && i_message_sent && !w_cls_ack) ||
                       ((r_state == S_WAIT_ACK) && i_message_acked) ||
                       (w_timeout && !w_retry);

    // Fresh issues use the arbitration winner; retries reload the class in flight.
    always_comb begin
        w_load_cls = r_cls;
        if (r_state == S_IDLE) w_load_cls = w_win;
    end

    assign o_busy = (r_state != S_IDLE);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state                   <= S_IDLE;
            r_cls                     <= C_NGA;
            r_pend_ball               <= 1'b0;
            r_pend_miss               <= 1'b0;
            r_pend_ng                 <= 1'b0;
            r_pend_nga                <= 1'b0;
            r_pend_ayt                <= 1'b0;
            r_ball_y                  <= '0;
            r_vel_x                   <= '0;
            r_vel_y                   <= '0;
            r_sign_y                  <= 1'b0;
            r_my_score                <= '0;
            r_your_score              <= '0;
            r_you_serve               <= 1'b0;
            r_serve_first             <= 1'b0;
            r_ack_cnt                 <= '0;
            r_retry_cnt               <= '0;
            r_idle_cnt                <= '0;
            o_send_new_message        <= 1'b0;
            o_ball_message_tx         <= 1'b0;
            o_miss_message_tx         <= 1'b0;
            o_new_game_message_tx     <= 1'b0;
            o_new_game_ack_message_tx <= 1'b0;
            o_are_you_there_tx        <= 1'b0;
            o_ball_y_tx               <= '0;
            o_velocity_x_tx           <= '0;
            o_velocity_y_tx           <= '0;
            o_sign_y_tx               <= 1'b0;
            o_my_score_tx             <= '0;
            o_your_score_tx           <= '0;
            o_you_should_serve_tx     <= 1'b0;
            o_you_serve_first_tx      <= 1'b0;
            o_link_lost               <= 1'b0;
        end else begin
            o_send_new_message <= 1'b0;
            o_link_lost        <= 1'b0;

            // Heartbeat timer: runs only while nothing is pending in IDLE.
            if (o_send_new_message) begin
                r_idle_cnt <= '0;
            end else if ((r_state == S_IDLE) && !w_any_pend) begin
                if (r_idle_cnt == IDLE_LAST) begin
                    r_idle_cnt <= '0;
                    r_pend_ayt <= 1'b1;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cls                     <= w_win;
                        o_new_game_ack_message_tx <= (w_win == C_NGA);
                        o_new_game_message_tx     <= (w_win == C_NG);
                        o_miss_message_tx         <= (w_win == C_MISS);
                        o_ball_message_tx         <= (w_win == C_BALL);
                        o_are_you_there_tx        <= (w_win == C_AYT);
                        o_send_new_message        <= 1'b1;
                        r_state                   <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_HOLD;
                // Sender gets one cycle to drop message_sent before it is trusted again.
                S_HOLD:  r_state <= S_SENDING;
                S_SENDING: begin
                    if (i_message_sent) begin
                        if (w_cls_ack) begin
                            r_ack_cnt <= '0;
                            r_state   <= S_WAIT_ACK;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (i_message_acked) begin
                        r_retry_cnt <= '0;
                        r_state     <= S_IDLE;
                    end else if (r_ack_cnt == ACK_LAST) begin
                        r_ack_cnt <= '0;
                        if (w_retry) begin
                            r_retry_cnt        <= r_retry_cnt + 1'b1;
                            o_send_new_message <= 1'b1;
                            r_state            <= S_ISSUE;
                        end else begin
                            r_retry_cnt <= '0;
                            o_link_lost <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_load) begin
                case (w_load_cls)
                    C_BALL: begin
                        o_ball_y_tx     <= r_ball_y;
                        o_velocity_x_tx <= r_vel_x;
                        o_velocity_y_tx <= r_vel_y;
                        o_sign_y_tx     <= r_sign_y;
                    end
                    C_MISS: begin
                        o_my_score_tx         <= r_my_score;
                        o_your_score_tx       <= r_your_score;
                        o_you_should_serve_tx <= r_you_serve;
                    end
                    C_NG:    o_you_serve_first_tx <= r_serve_first;
                    default: ;
                endcase
            end

            if (w_done) begin
                o_ball_message_tx         <= 1'b0;
                o_miss_message_tx         <= 1'b0;
                o_new_game_message_tx     <= 1'b0;
                o_new_game_ack_message_tx <= 1'b0;
                o_are_you_there_tx        <= 1'b0;
                case (r_cls)
                    C_NGA:   r_pend_nga  <= 1'b0;
                    C_NG:    r_pend_ng   <= 1'b0;
                    C_MISS:  r_pend_miss <= 1'b0;
                    C_BALL:  r_pend_ball <= 1'b0;
                    default: r_pend_ayt  <= 1'b0;
                endcase
            end

            // Request capture comes last so a new request beats a same-cycle completion clear.
            if (i_req_ball) begin
                r_pend_ball <= 1'b1;
                r_ball_y    <= i_ball_y_in;
                r_vel_x     <= i_velocity_x_in;
                r_vel_y     <= i_velocity_y_in;
                r_sign_y    <= i_sign_y_in;
            end
            if (i_req_miss) begin
                r_pend_miss  <= 1'b1;
                r_my_score   <= i_my_score_in;
                r_your_score <= i_your_score_in;
                r_you_serve  <= i_you_should_serve_in;
            end
            if (i_req_new_game) begin
                r_pend_ng     <= 1'b1;
                r_serve_first <= i_you_serve_first_in;
            end
            if (i_req_new_game_ack) begin
                r_pend_nga <= 1'b1;
            end
        end
    end

endmodule

// File: doc/message_tx_scheduler.md
Name: message_tx_scheduler

Overview:
- Sits between game logic and CommunicationSender. Accepts one-cycle send requests for each message class and latches their payloads.
- Arbitrates by fixed priority and drives the sender's one-hot type selects, payload fields and the send_new_message handshake.
- Tracks acknowledgements for ack-required messages, with timeout and retry, and emits a periodic are_you_there heartbeat when the link is quiet.

Parameters:
- ACK_TIMEOUT, 50000: cycles to wait for message_acked after a send completes.
- MAX_RETRIES, 3: resends allowed after the first attempt before declaring the link lost.
- HEARTBEAT_CYCLES, 5000000: idle cycles before are_you_there is sent automatically.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high
- req_ball  in  1  pulse; latch ball payload
- ball_y_in  in  9; velocity_x_in  in  4; velocity_y_in  in  4; sign_y_in  in  1  ball payload
- req_miss  in  1  pulse; latch miss payload
- my_score_in  in  5; your_score_in  in  5; you_should_serve_in  in  1  miss payload
- req_new_game  in  1  pulse; you_serve_first_in  in  1
- req_new_game_ack  in  1  pulse
- message_sent  in  1  sender idle/complete (level)
- message_acked  in  1  pulse from receiver
- send_new_message  out  1  one-cycle start pulse to sender
- ball_message_tx, miss_message_tx, new_game_message_tx, new_game_ack_message_tx, are_you_there_tx  out  1 each  one-hot type select
- ball_y_tx 9, velocity_x_tx 4, velocity_y_tx 4, sign_y_tx 1, my_score_tx 5, your_score_tx 5, you_should_serve_tx 1, you_serve_first_tx 1  out  payload
- busy  out  1  state != IDLE
- link_lost  out  1  one-cycle pulse on retry exhaustion

Behaviour:
- Reset:
  - All outputs 0, all pending flags cleared, all counters 0, state IDLE.
  - Reset mid-transfer abandons the message silently; link_lost does not pulse.
- Request capture:
  - req_X sets pending_X and latches its payload in the same cycle, in any state.
  - A repeat req_X while pending_X is set overwrites the payload; the latest wins, and a retry sends the newest payload.
- Priority, evaluated in IDLE only: new_game_ack > new_game > miss > ball > heartbeat.
  - Heartbeat becomes pending when the idle counter reaches HEARTBEAT_CYCLES-1.
  - The idle counter resets on every send_new_message.
- Ack classes:
  - ball, miss and new_game require an ack.
  - new_game_ack and are_you_there clear their pending flag once the send completes.
- States:
  - IDLE: if any pending flag is set and message_sent=1, drive the winner's type select and payload registers, and go to ISSUE.
  - ISSUE: assert send_new_message for exactly one cycle, then go to HOLD.
  - HOLD: one cycle in which message_sent is ignored (the sender is allowed one cycle to drop it), then go to SENDING.
  - SENDING: wait for message_sent=1.
    - Ack-required message: go to WAIT_ACK and clear the ack counter.
    - Otherwise: clear pending, clear type selects, go to IDLE.
  - WAIT_ACK:
    - message_acked=1: clear pending, retry count and type selects; go to IDLE.
    - Ack counter reaches ACK_TIMEOUT-1 with retry count < MAX_RETRIES: increment retry count, reload the payload of the same class, go to ISSUE.
    - Retry count = MAX_RETRIES: pulse link_lost, clear that pending flag, go to IDLE.
- Output stability: type select and payload are stable from ISSUE through the exit of SENDING/WAIT_ACK. Exactly one type select is high when non-idle.
- Edge cases:
  - message_acked outside WAIT_ACK is ignored.
  - A simultaneous ack and timeout resolves as ack.
  - A higher-priority request arriving during WAIT_ACK waits; no preemption.
- Counter widths are $clog2(param+1); no wrap is possible because each counter is cleared at its terminal count.

Test Plan (ACK_TIMEOUT=8, MAX_RETRIES=2, HEARTBEAT_CYCLES=64 for sim):
1. Ball with ack: req_ball with ball_y_in=9'd200, velocity_x_in=3, message_sent=1 -> send_new_message pulses 2 cycles later with ball_message_tx=1 and ball_y_tx=200. Sender model drops message_sent for 10 cycles; ack 3 cycles after it rises -> busy falls, no retry.
2. Priority: req_ball, req_miss and req_new_game_ack in the same cycle -> sends in order new_game_ack, miss, ball. Each ack-required send is acked.
3. Retry: req_miss with scores 5/3 and no ack -> 3 send_new_message pulses each 8 cycles after completion, then a single link_lost pulse, then busy=0.
4. Overwrite: req_ball ball_y=10, then during WAIT_ACK req_ball ball_y=20, then timeout -> resend carries ball_y_tx=20.
5. Heartbeat: no requests for 64 cycles -> are_you_there_tx=1 with a send_new_message pulse; no WAIT_ACK entered.
6. Reset asserted in SENDING -> next cycle all outputs 0 and state IDLE; no link_lost pulse and no subsequent send.
